// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use / RAW stalls, and wrong-path squashing after control transfers.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int BR_MODE   = 0,
  parameter int CTRL_WAIT = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              ex_we_i,
  input  logic              mem_we_i,
  input  logic              wb_we_i,
  input  logic              ex_is_load_i,
  input  logic              ex_redirect_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              pc_hold_o,
  output logic              ifid_hold_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              ctrl_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] WAIT_LOAD = 3'(CTRL_WAIT);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic m1Ex, m1Mem, m1Wb, m2Ex, m2Mem, m2Wb;
  logic [1:0] fwdA, fwdB;
  logic dataStall, isCtrl, redirect, inWait, stall;

  // Register x0 and non-writing destinations never match.
  assign m1Ex  = id_rs1_used_i & (id_rs1_i != '0) & ex_we_i  & (ex_rd_i  == id_rs1_i);
  assign m1Mem = id_rs1_used_i & (id_rs1_i != '0) & mem_we_i & (mem_rd_i == id_rs1_i);
  assign m1Wb  = id_rs1_used_i & (id_rs1_i != '0) & wb_we_i  & (wb_rd_i  == id_rs1_i);
  assign m2Ex  = id_rs2_used_i & (id_rs2_i != '0) & ex_we_i  & (ex_rd_i  == id_rs2_i);
  assign m2Mem = id_rs2_used_i & (id_rs2_i != '0) & mem_we_i & (mem_rd_i == id_rs2_i);
  assign m2Wb  = id_rs2_used_i & (id_rs2_i != '0) & wb_we_i  & (wb_rd_i  == id_rs2_i);

  assign isCtrl   = (id_opcode_i == OP_BRANCH) | (id_opcode_i == OP_JAL) |
                    (id_opcode_i == OP_JALR);
  assign redirect = (BR_MODE == 1) && ex_redirect_i;
  assign inWait   = (state_q == WAIT);

  always_comb begin
    fwdA      = 2'b00;
    fwdB      = 2'b00;
    dataStall = m1Ex | m1Mem | m1Wb | m2Ex | m2Mem | m2Wb;
    if (FWD_EN != 0) begin
      if (m1Ex)       fwdA = 2'b01;
      else if (m1Mem) fwdA = 2'b10;
      else if (m1Wb)  fwdA = 2'b11;
      if (m2Ex)       fwdB = 2'b01;
      else if (m2Mem) fwdB = 2'b10;
      else if (m2Wb)  fwdB = 2'b11;
      dataStall = (m1Ex | m2Ex) & ex_is_load_i;
    end
  end

  // A stalled control instruction stays in ID, so the window opens only once it moves on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if ((BR_MODE == 0) && isCtrl && !dataStall) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    stall         = dataStall & ~inWait & ~redirect;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    ctrl_busy_o   = 1'b0;
    fwd_a_o       = 2'b00;
    fwd_b_o       = 2'b00;
    if (rst_n_i) begin
      pc_hold_o     = stall;
      ifid_hold_o   = stall;
      idex_bubble_o = stall | redirect;
      ifid_flush_o  = inWait | redirect;
      ctrl_busy_o   = inWait | redirect;
      fwd_a_o       = fwdA;
      fwd_b_o       = fwdB;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (pc_hold_o && (stallCnt_q != '1))    stallCnt_d = stallCnt_q + CNT_W'(1);
    if (ifid_flush_o && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; four builds share one stimulus:
// u0 forwarding/wait, u1 stall-only, u2 predict-not-taken, u3 4-bit counters.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] NOP  = 7'h13;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic       clk;
  logic       rstN;
  logic [4:0] idRs1, idRs2, exRd, memRd, wbRd;
  logic       idRs1Used, idRs2Used, exWe, memWe, wbWe, exIsLoad, exRedirect;
  logic [6:0] idOpcode;

  logic [3:0][1:0]  fwdA, fwdB;
  logic [3:0]       pcHold, ifidHold, idexBubble, ifidFlush, ctrlBusy;
  logic [2:0][15:0] stallCnt, flushCnt;
  logic [3:0]       satStall, satFlush;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_MODE(0), .CTRL_WAIT(3), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_n_i(rstN), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_rs1_used_i(idRs1Used), .id_rs2_used_i(idRs2Used), .id_opcode_i(idOpcode),
    .ex_rd_i(exRd), .mem_rd_i(memRd), .wb_rd_i(wbRd), .ex_we_i(exWe), .mem_we_i(memWe),
    .wb_we_i(wbWe), .ex_is_load_i(exIsLoad), .ex_redirect_i(exRedirect),
    .fwd_a_o(fwdA[0]), .fwd_b_o(fwdB[0]), .pc_hold_o(pcHold[0]), .ifid_hold_o(ifidHold[0]),
    .idex_bubble_o(idexBubble[0]), .ifid_flush_o(ifidFlush[0]), .ctrl_busy_o(ctrlBusy[0]),
    .stall_cnt_o(stallCnt[0]), .flush_cnt_o(flushCnt[0]));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_MODE(0), .CTRL_WAIT(3), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_n_i(rstN), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_rs1_used_i(idRs1Used), .id_rs2_used_i(idRs2Used), .id_opcode_i(idOpcode),
    .ex_rd_i(exRd), .mem_rd_i(memRd), .wb_rd_i(wbRd), .ex_we_i(exWe), .mem_we_i(memWe),
    .wb_we_i(wbWe), .ex_is_load_i(exIsLoad), .ex_redirect_i(exRedirect),
    .fwd_a_o(fwdA[1]), .fwd_b_o(fwdB[1]), .pc_hold_o(pcHold[1]), .ifid_hold_o(ifidHold[1]),
    .idex_bubble_o(idexBubble[1]), .ifid_flush_o(ifidFlush[1]), .ctrl_busy_o(ctrlBusy[1]),
    .stall_cnt_o(stallCnt[1]), .flush_cnt_o(flushCnt[1]));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_MODE(1), .CTRL_WAIT(3), .CNT_W(16)) u2 (
    .clk_i(clk), .rst_n_i(rstN), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_rs1_used_i(idRs1Used), .id_rs2_used_i(idRs2Used), .id_opcode_i(idOpcode),
    .ex_rd_i(exRd), .mem_rd_i(memRd), .wb_rd_i(wbRd), .ex_we_i(exWe), .mem_we_i(memWe),
    .wb_we_i(wbWe), .ex_is_load_i(exIsLoad), .ex_redirect_i(exRedirect),
    .fwd_a_o(fwdA[2]), .fwd_b_o(fwdB[2]), .pc_hold_o(pcHold[2]), .ifid_hold_o(ifidHold[2]),
    .idex_bubble_o(idexBubble[2]), .ifid_flush_o(ifidFlush[2]), .ctrl_busy_o(ctrlBusy[2]),
    .stall_cnt_o(stallCnt[2]), .flush_cnt_o(flushCnt[2]));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_MODE(0), .CTRL_WAIT(3), .CNT_W(4)) u3 (
    .clk_i(clk), .rst_n_i(rstN), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_rs1_used_i(idRs1Used), .id_rs2_used_i(idRs2Used), .id_opcode_i(idOpcode),
    .ex_rd_i(exRd), .mem_rd_i(memRd), .wb_rd_i(wbRd), .ex_we_i(exWe), .mem_we_i(memWe),
    .wb_we_i(wbWe), .ex_is_load_i(exIsLoad), .ex_redirect_i(exRedirect),
    .fwd_a_o(fwdA[3]), .fwd_b_o(fwdB[3]), .pc_hold_o(pcHold[3]), .ifid_hold_o(ifidHold[3]),
    .idex_bubble_o(idexBubble[3]), .ifid_flush_o(ifidFlush[3]), .ctrl_busy_o(ctrlBusy[3]),
    .stall_cnt_o(satStall), .flush_cnt_o(satFlush));

  // Drives one full cycle's worth of ID/EX/MEM/WB inputs.
  task automatic applyStimulus(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                               input logic rs2u, input logic [6:0] opc, input logic [4:0] xRd,
                               input logic xWe, input logic xLd, input logic [4:0] mRd,
                               input logic mWe, input logic [4:0] wRd, input logic wWe,
                               input logic redir);
    idRs1 = rs1; idRs1Used = rs1u; idRs2 = rs2; idRs2Used = rs2u; idOpcode = opc;
    exRd = xRd; exWe = xWe; exIsLoad = xLd; memRd = mRd; memWe = mWe;
    wbRd = wRd; wbWe = wWe; exRedirect = redir;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    applyStimulus(0, 0, 7, 1, BR, 7, 1, 1, 0, 0, 0, 0, 1);
    #1;
    checks++; if (pcHold[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_pc_hold: got %0b expected 0", pcHold[0]); end
    checks++; if (idexBubble[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_idex_bubble: got %0b expected 0", idexBubble[0]); end
    checks++; if (fwdB[0] !== 2'b00) begin failures++; $display("[TB] FAIL rst_fwd_b: got %0b expected 00", fwdB[0]); end
    checks++; if (ifidFlush[2] !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush_redirect: got %0b expected 0", ifidFlush[2]); end
    checks++; if (ctrlBusy[2] !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_redirect: got %0b expected 0", ctrlBusy[2]); end
    @(negedge clk);
    #1;
    checks++; if (stallCnt[0] !== 16'd0) begin failures++; $display("[TB] FAIL rst_stall_cnt: got %0d expected 0", stallCnt[0]); end
    checks++; if (flushCnt[2] !== 16'd0) begin failures++; $display("[TB] FAIL rst_flush_cnt: got %0d expected 0", flushCnt[2]); end
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_idle_after: got %0b expected 0", ifidFlush[0]); end
  endtask

  task automatic test_forwarding();
    doReset();
    @(negedge clk); applyStimulus(5, 1, 0, 0, NOP, 5, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwdA[0] !== 2'b01) begin failures++; $display("[TB] FAIL fwd_ex: got %0b expected 01", fwdA[0]); end
    checks++; if (pcHold[0] !== 1'b0) begin failures++; $display("[TB] FAIL fwd_ex_no_stall: got %0b expected 0", pcHold[0]); end
    checks++; if (fwdA[1] !== 2'b00) begin failures++; $display("[TB] FAIL stallonly_fwd: got %0b expected 00", fwdA[1]); end
    checks++; if (pcHold[1] !== 1'b1) begin failures++; $display("[TB] FAIL stallonly_ex_stall: got %0b expected 1", pcHold[1]); end
    @(negedge clk); applyStimulus(5, 1, 0, 0, NOP, 5, 1, 0, 5, 1, 0, 0, 0); #1;
    checks++; if (fwdA[0] !== 2'b01) begin failures++; $display("[TB] FAIL fwd_ex_over_mem: got %0b expected 01", fwdA[0]); end
    @(negedge clk); applyStimulus(5, 1, 0, 0, NOP, 5, 0, 0, 5, 1, 5, 1, 0); #1;
    checks++; if (fwdA[0] !== 2'b10) begin failures++; $display("[TB] FAIL fwd_mem_over_wb: got %0b expected 10", fwdA[0]); end
    @(negedge clk); applyStimulus(5, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 5, 1, 0); #1;
    checks++; if (fwdA[0] !== 2'b11) begin failures++; $display("[TB] FAIL fwd_wb: got %0b expected 11", fwdA[0]); end
    @(negedge clk); applyStimulus(0, 1, 0, 0, NOP, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwdA[0] !== 2'b00) begin failures++; $display("[TB] FAIL fwd_x0: got %0b expected 00", fwdA[0]); end
    checks++; if (pcHold[1] !== 1'b0) begin failures++; $display("[TB] FAIL stallonly_x0: got %0b expected 0", pcHold[1]); end
    @(negedge clk); applyStimulus(0, 0, 9, 0, NOP, 9, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwdB[0] !== 2'b00) begin failures++; $display("[TB] FAIL fwd_rs2_unused: got %0b expected 00", fwdB[0]); end
    @(negedge clk); applyStimulus(0, 0, 9, 1, NOP, 9, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwdB[0] !== 2'b01) begin failures++; $display("[TB] FAIL fwd_rs2_ex: got %0b expected 01", fwdB[0]); end
  endtask

  task automatic test_load_use();
    doReset();
    @(negedge clk); applyStimulus(0, 0, 7, 1, NOP, 7, 1, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (pcHold[0] !== 1'b1) begin failures++; $display("[TB] FAIL lu_pc_hold: got %0b expected 1", pcHold[0]); end
    checks++; if (ifidHold[0] !== 1'b1) begin failures++; $display("[TB] FAIL lu_ifid_hold: got %0b expected 1", ifidHold[0]); end
    checks++; if (idexBubble[0] !== 1'b1) begin failures++; $display("[TB] FAIL lu_bubble: got %0b expected 1", idexBubble[0]); end
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL lu_no_flush: got %0b expected 0", ifidFlush[0]); end
    @(negedge clk); applyStimulus(0, 0, 7, 1, NOP, 0, 0, 0, 7, 1, 0, 0, 0); #1;
    checks++; if (fwdB[0] !== 2'b10) begin failures++; $display("[TB] FAIL lu_fwd_mem: got %0b expected 10", fwdB[0]); end
    checks++; if (pcHold[0] !== 1'b0) begin failures++; $display("[TB] FAIL lu_released: got %0b expected 0", pcHold[0]); end
    checks++; if (stallCnt[0] !== 16'd1) begin failures++; $display("[TB] FAIL lu_stall_cnt: got %0d expected 1", stallCnt[0]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (stallCnt[0] !== 16'd1) begin failures++; $display("[TB] FAIL lu_stall_cnt_hold: got %0d expected 1", stallCnt[0]); end
  endtask

  task automatic test_stall_only();
    doReset();
    @(negedge clk); applyStimulus(3, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 3, 1, 0); #1;
    checks++; if (pcHold[1] !== 1'b1) begin failures++; $display("[TB] FAIL so_wb_stall: got %0b expected 1", pcHold[1]); end
    checks++; if (fwdA[1] !== 2'b00) begin failures++; $display("[TB] FAIL so_fwd_a: got %0b expected 00", fwdA[1]); end
    checks++; if (fwdA[0] !== 2'b11) begin failures++; $display("[TB] FAIL so_ref_fwd_wb: got %0b expected 11", fwdA[0]); end
    @(negedge clk); applyStimulus(0, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    checks++; if (pcHold[1] !== 1'b0) begin failures++; $display("[TB] FAIL so_x0_no_stall: got %0b expected 0", pcHold[1]); end
    @(negedge clk); applyStimulus(4, 1, 0, 0, NOP, 4, 1, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pcHold[1] !== 1'b1) begin failures++; $display("[TB] FAIL so_ex_stall: got %0b expected 1", pcHold[1]); end
    @(negedge clk); applyStimulus(4, 1, 0, 0, NOP, 0, 0, 0, 4, 1, 0, 0, 0); #1;
    checks++; if (pcHold[1] !== 1'b1) begin failures++; $display("[TB] FAIL so_mem_stall: got %0b expected 1", pcHold[1]); end
    @(negedge clk); applyStimulus(4, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 4, 1, 0); #1;
    checks++; if (ifidHold[1] !== 1'b1) begin failures++; $display("[TB] FAIL so_wb_hold: got %0b expected 1", ifidHold[1]); end
    @(negedge clk); applyStimulus(4, 1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (pcHold[1] !== 1'b0) begin failures++; $display("[TB] FAIL so_released: got %0b expected 0", pcHold[1]); end
    checks++; if (stallCnt[1] !== 16'd4) begin failures++; $display("[TB] FAIL so_stall_cnt: got %0d expected 4", stallCnt[1]); end
  endtask

  task automatic test_branch_wait();
    doReset();
    @(negedge clk); applyStimulus(0, 0, 0, 0, BR, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_t0_flush: got %0b expected 0", ifidFlush[0]); end
    @(negedge clk); applyStimulus(0, 0, 7, 1, NOP, 7, 1, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_t1_flush: got %0b expected 1", ifidFlush[0]); end
    checks++; if (ctrlBusy[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_t1_busy: got %0b expected 1", ctrlBusy[0]); end
    checks++; if (pcHold[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_stall_masked: got %0b expected 0", pcHold[0]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, JAL, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_t2_flush: got %0b expected 1", ifidFlush[0]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_t3_flush: got %0b expected 1", ifidFlush[0]); end
    @(negedge clk); #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_t4_idle: got %0b expected 0", ifidFlush[0]); end
    checks++; if (ctrlBusy[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_t4_busy: got %0b expected 0", ctrlBusy[0]); end
    checks++; if (flushCnt[0] !== 16'd3) begin failures++; $display("[TB] FAIL bw_flush_cnt: got %0d expected 3", flushCnt[0]); end
    checks++; if (stallCnt[0] !== 16'd0) begin failures++; $display("[TB] FAIL bw_stall_cnt: got %0d expected 0", stallCnt[0]); end
    @(negedge clk); #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_jal_ignored: got %0b expected 0", ifidFlush[0]); end
    // Control instruction held by a load-use stall opens its window one cycle late.
    @(negedge clk); applyStimulus(0, 0, 7, 1, JALR, 7, 1, 1, 0, 0, 0, 0, 0); #1;
    checks++; if (pcHold[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_held_stall: got %0b expected 1", pcHold[0]); end
    @(negedge clk); applyStimulus(0, 0, 7, 1, JALR, 0, 0, 0, 7, 1, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL bw_held_no_flush: got %0b expected 0", ifidFlush[0]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b1) begin failures++; $display("[TB] FAIL bw_held_flush: got %0b expected 1", ifidFlush[0]); end
    repeat (3) @(negedge clk); #1;
    checks++; if (flushCnt[0] !== 16'd6) begin failures++; $display("[TB] FAIL bw_flush_cnt2: got %0d expected 6", flushCnt[0]); end
  endtask

  task automatic test_redirect();
    doReset();
    @(negedge clk); applyStimulus(0, 0, 7, 1, NOP, 7, 1, 1, 0, 0, 0, 0, 1); #1;
    checks++; if (ifidFlush[2] !== 1'b1) begin failures++; $display("[TB] FAIL rd_flush: got %0b expected 1", ifidFlush[2]); end
    checks++; if (idexBubble[2] !== 1'b1) begin failures++; $display("[TB] FAIL rd_bubble: got %0b expected 1", idexBubble[2]); end
    checks++; if (pcHold[2] !== 1'b0) begin failures++; $display("[TB] FAIL rd_pc_hold: got %0b expected 0", pcHold[2]); end
    checks++; if (ifidHold[2] !== 1'b0) begin failures++; $display("[TB] FAIL rd_ifid_hold: got %0b expected 0", ifidHold[2]); end
    checks++; if (ctrlBusy[2] !== 1'b1) begin failures++; $display("[TB] FAIL rd_busy: got %0b expected 1", ctrlBusy[2]); end
    checks++; if (pcHold[0] !== 1'b1) begin failures++; $display("[TB] FAIL rd_mode0_ignores: got %0b expected 1", pcHold[0]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, BR, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ctrlBusy[2] !== 1'b0) begin failures++; $display("[TB] FAIL rd_busy_off: got %0b expected 0", ctrlBusy[2]); end
    checks++; if (flushCnt[2] !== 16'd1) begin failures++; $display("[TB] FAIL rd_flush_cnt: got %0d expected 1", flushCnt[2]); end
    checks++; if (stallCnt[2] !== 16'd0) begin failures++; $display("[TB] FAIL rd_stall_cnt: got %0d expected 0", stallCnt[2]); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[2] !== 1'b0) begin failures++; $display("[TB] FAIL rd_no_wait: got %0b expected 0", ifidFlush[2]); end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    @(negedge clk); applyStimulus(0, 0, 0, 0, BR, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (ifidFlush[0] !== 1'b1) begin failures++; $display("[TB] FAIL rw_t1_flush: got %0b expected 1", ifidFlush[0]); end
    @(negedge clk); rstN = 1'b0; #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL rw_forced_flush: got %0b expected 0", ifidFlush[0]); end
    checks++; if (ctrlBusy[0] !== 1'b0) begin failures++; $display("[TB] FAIL rw_forced_busy: got %0b expected 0", ctrlBusy[0]); end
    @(negedge clk); rstN = 1'b1; #1;
    checks++; if (ifidFlush[0] !== 1'b0) begin failures++; $display("[TB] FAIL rw_aborted: got %0b expected 0", ifidFlush[0]); end
    checks++; if (flushCnt[0] !== 16'd0) begin failures++; $display("[TB] FAIL rw_flush_cnt: got %0d expected 0", flushCnt[0]); end
    @(negedge clk); #1;
    checks++; if (ctrlBusy[0] !== 1'b0) begin failures++; $display("[TB] FAIL rw_stays_idle: got %0b expected 0", ctrlBusy[0]); end
  endtask

  task automatic test_saturation();
    doReset();
    @(negedge clk); applyStimulus(0, 0, 7, 1, NOP, 7, 1, 1, 0, 0, 0, 0, 0);
    repeat (10) @(negedge clk); #1;
    checks++; if (satStall !== 4'd10) begin failures++; $display("[TB] FAIL sat_mid: got %0d expected 10", satStall); end
    repeat (10) @(negedge clk); #1;
    checks++; if (satStall !== 4'd15) begin failures++; $display("[TB] FAIL sat_stall_cnt: got %0d expected 15", satStall); end
    checks++; if (stallCnt[0] !== 16'd20) begin failures++; $display("[TB] FAIL sat_wide_cnt: got %0d expected 20", stallCnt[0]); end
    checks++; if (satFlush !== 4'd0) begin failures++; $display("[TB] FAIL sat_flush_cnt: got %0d expected 0", satFlush); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstN     = 1'b0;
    applyStimulus(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_forwarding();
    test_load_use();
    test_stall_only();
    test_branch_wait();
    test_redirect();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard controller for the 5-stage RISC-V pipeline: the successor to the fixed stall-only hazard unit. It sits beside the ID stage and decides, every cycle, whether each ID source operand comes from the register file or is forwarded from EX/MEM/WB. It also decides when the front end must stall for a load-use or unforwardable RAW hazard, and how wrong-path instructions are squashed after a control-transfer instruction. Two build-time modes are provided: full forwarding or stall-only, and conservative branch wait or predict-not-taken flush. Saturating performance counters are included.

## Interface
Parameters:
- REG_AW, 5, register-address width
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW match
- BR_MODE, 0, 0 = conservative wait after control opcode in ID; 1 = predict-not-taken, flush on ex_redirect
- CTRL_WAIT, 3, squash cycles in BR_MODE 0 (legal range 1..7)
- CNT_W, 16, perf-counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  clock; all state updates on posedge
  - rst_n  in  1  synchronous active-low reset
- ID-stage inputs:
  - id_rs1, id_rs2  in  REG_AW  ID source registers
  - id_rs1_used, id_rs2_used  in  1  operand actually read (rs2 for R-type, store, branch)
  - id_opcode  in  7  ID instruction opcode
- EX/MEM/WB destination inputs:
  - ex_rd, mem_rd, wb_rd  in  REG_AW  destination registers
  - ex_we, mem_we, wb_we  in  1  destination will be written
  - ex_is_load  in  1  instruction in EX is a load
- ex_redirect  in  1  branch taken / jump resolved in EX (used only when BR_MODE=1)
- Outputs:
  - fwd_a, fwd_b  out  2  operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
  - pc_hold  out  1  hold PC
  - ifid_hold  out  1  hold IF/ID register
  - idex_bubble  out  1  load NOP into ID/EX
  - ifid_flush  out  1  replace IF/ID contents with NOP
  - ctrl_busy  out  1  squash window active
  - stall_cnt, flush_cnt  out  CNT_W  saturating counts of stall cycles and flush cycles

## Operation
- Match rule, per operand x ∈ {1,2} and stage s ∈ {EX,MEM,WB}: m_xs = id_rsx_used & (id_rsx != 0) & s_we & (s_rd == id_rsx).
- FWD_EN=1:
  - fwd_x is the youngest match, with priority EX > MEM > WB; otherwise 00.
  - data_stall = (m_1EX | m_2EX) & ex_is_load.
  - A load in MEM forwards (10) without a stall.
- FWD_EN=0:
  - fwd_x = 00 always.
  - data_stall = OR of all six m_xs.
- data_stall drives pc_hold = ifid_hold = idex_bubble = 1.
- Control opcodes are 1100011 (branch), 1101111 (JAL) and 1100111 (JALR).
- BR_MODE=0 FSM (IDLE, WAIT), with a 3-bit counter cnt:
  - IDLE:
    - If a control opcode is in ID and data_stall=0, go to WAIT with cnt = CTRL_WAIT.
    - If data_stall=1, stay in IDLE; the control instruction is held.
  - WAIT:
    - ifid_flush=1 and ctrl_busy=1; cnt decrements each cycle.
    - Exit to IDLE when cnt reaches 1.
    - Control opcodes in ID are ignored because they are squashed.
    - data_stall is masked to 0 because ID holds a NOP.
    - pc_hold=0.
- BR_MODE=1:
  - In any cycle with ex_redirect=1, ifid_flush=1 and idex_bubble=1, and pc_hold=ifid_hold=0. Redirect overrides data_stall.
  - FSM stays in IDLE; ctrl_busy = ex_redirect.
- Counters:
  - stall_cnt increments on every cycle where pc_hold=1.
  - flush_cnt increments on every cycle where ifid_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding selects and stall/flush outputs are combinational from inputs and current state, and are valid in the same cycle.
- FSM and counters update on posedge clk.
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE, cnt=0, stall_cnt=flush_cnt=0.
  - While rst_n=0, all of the following are forced 0: pc_hold, ifid_hold, idex_bubble, ifid_flush, ctrl_busy, fwd_a, fwd_b.
- Reset asserted mid-WAIT aborts the window. The first cycle after reset is IDLE.
- Load-use costs exactly 1 stall cycle with FWD_EN=1. With FWD_EN=0, a RAW match against EX costs up to 3 stall cycles, until the writer leaves WB.
- BR_MODE=0: a control instruction in ID at cycle T gives ifid_flush=1 for cycles T+1 .. T+CTRL_WAIT, then returns to IDLE at T+CTRL_WAIT+1.
- Register x0 never matches. A destination with we=0 never matches.

## Test plan
- FWD_EN=1, ex: rd=5, we=1, load=0; id_rs1=5 used → fwd_a=01, pc_hold=0. With mem_rd=5 also matching, EX still wins (01).
- FWD_EN=1, ex_is_load=1, ex_rd=7, id_rs2=7 used → pc_hold=ifid_hold=idex_bubble=1 for 1 cycle. Next cycle, with the load in MEM, fwd_b=10 and stall=0. stall_cnt=1.
- FWD_EN=0, wb_rd=3, id_rs1=3 → pc_hold=1 and fwd_a=00. id_rs1=0 with wb_rd=0 → no stall.
- BR_MODE=0, CTRL_WAIT=3, opcode 1100011 in ID at T → ifid_flush=1 at T+1..T+3, IDLE at T+4, flush_cnt=3. A JAL arriving at T+2 does not extend the window.
- BR_MODE=1, ex_redirect=1 concurrent with a load-use match → ifid_flush=idex_bubble=1, pc_hold=0.
- rst_n=0 during WAIT at T+2 → all outputs 0 and counters 0. Saturation check: with CNT_W=4, 20 stall cycles → stall_cnt=15.
